imem_load_ctrl: RTL and testbench

Sequences the instruction memory between two users: the IF-stage fetch path and a byte-serial program-load port (boot loader / debug). In normal operation fetch addresses pass straight to the memory. During a load session the block holds the core and stalls fetch. It assembles incoming bytes little-endian into 32-bit words and issues one memory write per word at consecutive word addresses. It sits in 01_IF between the fetch logic and the instruction memory's address/write port.

---
 rtl/imem_load_ctrl.sv | 177 +++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
//
// Arbitrates the instruction memory address/write port between the IF-stage
// fetch path and a byte-serial program-load port (boot loader / debug).
//
// Outside a load session, fetch addresses pass straight through to the memory
// and every fetch request is granted in the same cycle. A load session holds
// the core, stalls fetch, packs incoming bytes little-endian into 32-bit
// words, and writes each completed word at consecutive word addresses
// starting at BOOT_ADDR. A trailing partial word is discarded and flagged.
//
// Ports
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   load_start_i       pulse: open a load session (ignored unless idle)
//   load_end_i         pulse: close the current load session
//   load_byte_valid_i  load byte present
//   load_byte_i        load byte, lane order little-endian within a word
//   load_byte_ready_o  load port can accept a byte this cycle
//   fetch_req_i        IF instruction read request
//   fetch_addr_i       IF byte address
//   fetch_gnt_o        fetch read served this cycle
//   mem_addr_o         byte address to the instruction memory
//   mem_we_o           word write strobe to the instruction memory
//   mem_wdata_o        write word
//   core_hold_o        holds PC/pipeline while a session is active
//   load_done_o        pulse: session finished
//   load_err_o         with load_done_o: session ended on a partial word
//
// Load port handshake: a byte transfers on a rising edge where both
// load_byte_valid_i and load_byte_ready_o are high. The source may hold
// valid high with a stable byte while ready is low; ready never depends
// combinationally on valid.
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int unsigned         IMEM_W    = 13,
    parameter logic [IMEM_W-1:0]   BOOT_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic              load_end_i,
    input  logic              load_byte_valid_i,
    input  logic [7:0]        load_byte_i,
    output logic              load_byte_ready_o,
    input  logic              fetch_req_i,
    input  logic [IMEM_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic [IMEM_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_hold_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_e;

    state_e            state_q;
    logic [IMEM_W-1:0] wr_ptr_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       word_q;
    logic              end_pend_q;

    // Registered outputs, updated together with the state transition so each
    // one is a clean flop that matches the state it belongs to.
    logic              hold_q;
    logic              ready_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;

    logic              byte_acc;
    logic [1:0]        byte_cnt_d;
    logic              word_done;

    // ready_q is high exactly in COLLECT, so it doubles as the state qualifier.
    assign byte_acc   = load_byte_valid_i & ready_q;
    assign byte_cnt_d = byte_acc ? (byte_cnt_q + 2'd1) : byte_cnt_q;
    assign word_done  = byte_acc & (byte_cnt_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            end_pend_q <= 1'b0;
            hold_q     <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        state_q    <= COLLECT;
                        wr_ptr_q   <= BOOT_ADDR;
                        byte_cnt_q <= 2'd0;
                        end_pend_q <= 1'b0;
                        hold_q     <= 1'b1;
                        ready_q    <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (byte_acc) begin
                        word_q[{byte_cnt_q, 3'b000} +: 8] <= load_byte_i;
                        byte_cnt_q <= byte_cnt_d;
                    end
                    if (word_done) begin
                        // An end arriving with the last byte is deferred until
                        // the word has been written.
                        state_q    <= WRITE;
                        end_pend_q <= load_end_i;
                        ready_q    <= 1'b0;
                        we_q       <= 1'b1;
                    end else if (load_end_i) begin
                        state_q <= FINISH;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= (byte_cnt_d != 2'd0);
                    end
                end

                WRITE: begin
                    // Natural wrap at the top of the address space.
                    wr_ptr_q <= wr_ptr_q + IMEM_W'(4);
                    // An end seen during the write cycle itself is honoured
                    // immediately; there is no COLLECT cycle left to notice it.
                    if (end_pend_q || load_end_i) begin
                        state_q    <= FINISH;
                        end_pend_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= COLLECT;
                        ready_q <= 1'b1;
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // hold_q is low only in IDLE, which is where fetch owns the memory port.
    assign fetch_gnt_o       = fetch_req_i & ~hold_q;
    assign mem_addr_o        = hold_q ? wr_ptr_q : fetch_addr_i;
    assign mem_we_o          = we_q;
    assign mem_wdata_o       = word_q;
    assign load_byte_ready_o = ready_q;
    assign core_hold_o       = hold_q;
    assign load_done_o       = done_q;
    assign load_err_o        = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_end;
  logic        bvalid;
  logic [7:0]  bbyte;
  logic        fetch_req;
  logic [12:0] fetch_addr;

  logic        ready0, gnt0, we0, hold0, done0, err0;
  logic [12:0] addr0;
  logic [31:0] wdata0;
  logic        ready1, gnt1, we1, hold1, done1, err1;
  logic [12:0] addr1;
  logic [31:0] wdata1;

  int n_vec = 0;
  int n_err = 0;

  logic [44:0] exp0_q[$];
  logic [44:0] exp1_q[$];
  logic [12:0] ptr0;
  logic [12:0] ptr1;

  logic [7:0]  bt[3][4];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_load_ctrl #(.IMEM_W(13), .BOOT_ADDR(13'h0000)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .load_start_i(load_start), .load_end_i(load_end),
    .load_byte_valid_i(bvalid), .load_byte_i(bbyte), .load_byte_ready_o(ready0),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(gnt0),
    .mem_addr_o(addr0), .mem_we_o(we0), .mem_wdata_o(wdata0),
    .core_hold_o(hold0), .load_done_o(done0), .load_err_o(err0)
  );

  imem_load_ctrl #(.IMEM_W(13), .BOOT_ADDR(13'h1FFC)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .load_start_i(load_start), .load_end_i(load_end),
    .load_byte_valid_i(bvalid), .load_byte_i(bbyte), .load_byte_ready_o(ready1),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(gnt1),
    .mem_addr_o(addr1), .mem_we_o(we1), .mem_wdata_o(wdata1),
    .core_hold_o(hold1), .load_done_o(done1), .load_err_o(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // control bits {hold, ready, gnt, done, err}, same expectation for both instances
  task automatic chk_ctl(input string tag, input logic [4:0] e);
    chk(tag, {54'd0, hold0, ready0, gnt0, done0, err0, hold1, ready1, gnt1, done1, err1},
        {54'd0, e, e});
  endtask

  // driver: change inputs just after the rising edge, return at the falling edge
  task automatic apply(input logic s, input logic e, input logic v, input logic [7:0] b);
    @(posedge clk);
    #1;
    load_start = s;
    load_end   = e;
    bvalid     = v;
    bbyte      = b;
    @(negedge clk);
  endtask

  task automatic begin_session();
    ptr0 = 13'h0000;
    ptr1 = 13'h1FFC;
    apply(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // scoreboard: expected write = {byte address, word}
  task automatic push_w(input logic [31:0] d);
    exp0_q.push_back({ptr0, d});
    exp1_q.push_back({ptr1, d});
    ptr0 = ptr0 + 13'd4;
    ptr1 = ptr1 + 13'd4;
  endtask

  always @(negedge clk) begin
    if (rst_n && we0) begin
      if (exp0_q.size() == 0) chk("wr0_unexpected", {19'd0, addr0, wdata0}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("wr0", {19'd0, addr0, wdata0}, {19'd0, exp0_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && we1) begin
      if (exp1_q.size() == 0) chk("wr1_unexpected", {19'd0, addr1, wdata1}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("wr1", {19'd0, addr1, wdata1}, {19'd0, exp1_q.pop_front()});
    end
  end

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_end   = 1'b0;
    bvalid     = 1'b0;
    bbyte      = 8'h00;
    fetch_req  = 1'b0;
    fetch_addr = 13'h0000;
    ptr0       = 13'h0000;
    ptr1       = 13'h1FFC;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 4; i++)
        bt[w][i] = 8'($urandom_range(0, 255));

    // reset state
    #3;
    chk("rst_out0", {13'd0, ready0, gnt0, addr0, we0, wdata0, hold0, done0, err0}, 64'd0);
    chk("rst_out1", {13'd0, ready1, gnt1, addr1, we1, wdata1, hold1, done1, err1}, 64'd0);
    #9 rst_n = 1'b1;

    // fetch pass-through in idle
    @(posedge clk);
    #1;
    fetch_req  = 1'b1;
    fetch_addr = 13'h0010;
    #1;
    chk("fetch_addr0", {51'd0, addr0}, 64'h10);
    chk("fetch_addr1", {51'd0, addr1}, 64'h10);
    chk_ctl("fetch_idle", 5'b00100);

    // one word, end in a later collect cycle
    begin_session();
    chk_ctl("w1_start_idle", 5'b00100);
    apply(1'b0, 1'b0, 1'b1, 8'h13);
    chk_ctl("w1_collect", 5'b11000);
    chk("w1_addr0", {51'd0, addr0}, 64'h0);
    chk("w1_addr1", {51'd0, addr1}, 64'h1FFC);
    apply(1'b0, 1'b0, 1'b1, 8'h05);
    apply(1'b0, 1'b0, 1'b1, 8'h10);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    push_w(32'h0010_0513);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("w1_write", 5'b10000);
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    chk_ctl("w1_end_collect", 5'b11000);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("w1_finish", 5'b10010);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("w1_idle_gnt", 5'b00100);
    chk("w1_idle_addr", {51'd0, addr0}, 64'h10);

    // three words back-to-back, valid held through write cycles,
    // with a stray start mid-session that must be ignored
    begin_session();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        apply((w == 1) && (i == 2), 1'b0, 1'b1, bt[w][i]);
        chk_ctl($sformatf("w3_rdy_%0d_%0d", w, i), 5'b11000);
      end
      push_w({bt[w][3], bt[w][2], bt[w][1], bt[w][0]});
      if (w < 2) apply(1'b0, 1'b0, 1'b1, bt[w+1][0]);
      else       apply(1'b0, 1'b0, 1'b0, 8'h00);
      chk_ctl($sformatf("w3_write_%0d", w), 5'b10000);
    end
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    chk_ctl("w3_end_collect", 5'b11000);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("w3_finish", 5'b10010);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("w3_idle", 5'b00100);

    // partial word: discarded, flagged
    begin_session();
    apply(1'b0, 1'b0, 1'b1, 8'hAA);
    chk_ctl("part_collect", 5'b11000);
    apply(1'b0, 1'b0, 1'b1, 8'hBB);
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("part_finish_err", 5'b10011);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("part_idle", 5'b00100);

    // two words, end coincides with the last byte; dut1 wraps 0x1FFC -> 0x0000
    begin_session();
    apply(1'b0, 1'b0, 1'b1, 8'h11);
    apply(1'b0, 1'b0, 1'b1, 8'h22);
    apply(1'b0, 1'b0, 1'b1, 8'h33);
    apply(1'b0, 1'b0, 1'b1, 8'h44);
    push_w(32'h4433_2211);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("wrap_write_a", 5'b10000);
    apply(1'b0, 1'b0, 1'b1, 8'hDE);
    apply(1'b1, 1'b0, 1'b1, 8'hAD);
    apply(1'b0, 1'b0, 1'b1, 8'hBE);
    apply(1'b0, 1'b1, 1'b1, 8'hEF);
    push_w(32'hEFBE_ADDE);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("wrap_write_b", 5'b10000);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("wrap_finish", 5'b10010);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("wrap_idle", 5'b00100);

    // reset mid-word
    fetch_req  = 1'b0;
    fetch_addr = 13'h0000;
    begin_session();
    apply(1'b0, 1'b0, 1'b1, 8'h55);
    apply(1'b0, 1'b0, 1'b1, 8'h66);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out0", {13'd0, ready0, gnt0, addr0, we0, wdata0, hold0, done0, err0}, 64'd0);
    chk("mrst_out1", {13'd0, ready1, gnt1, addr1, we1, wdata1, hold1, done1, err1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    fetch_req  = 1'b1;
    fetch_addr = 13'h0020;
    #1;
    chk_ctl("mrst_idle", 5'b00100);
    chk("mrst_fetch_addr", {51'd0, addr0}, 64'h20);

    // fresh session after reset carries nothing from the lost partial word
    begin_session();
    apply(1'b0, 1'b0, 1'b1, 8'h01);
    apply(1'b0, 1'b0, 1'b1, 8'h02);
    apply(1'b0, 1'b0, 1'b1, 8'h03);
    apply(1'b0, 1'b0, 1'b1, 8'h04);
    push_w(32'h0403_0201);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("post_finish", 5'b10010);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk_ctl("post_idle", 5'b00100);

    repeat (3) apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sb0_drain", 64'(exp0_q.size()), 64'd0);
    chk("sb1_drain", 64'(exp1_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
